// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder scheduler.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_par.sv
// 4-bit parallel adder slice: out = a + b, carry = carry out of bit 3.
module adder_par
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] out,
    output logic                carry
);

    assign {carry, out} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_sched.sv
// Two-requester scheduler sharing one 4-bit adder slice, W-bit sum one nibble per cycle.
// Optional subtract support via macro ADDER_SCHED_SUB_EN (adds req0_sub / req1_sub ports).
module adder_sched
    import adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
`ifdef ADDER_SCHED_SUB_EN
    input  logic         req0_sub,
`endif
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
`ifdef ADDER_SCHED_SUB_EN
    input  logic         req1_sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_carry,
    output logic         res_id
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    logic [W-1:0]       a_q, b_q;
    logic               id_q, cy_q, last_q;
    logic [IDX_W-1:0]   idx;

    logic               grant0, grant1, acc0, acc1, sub_sel;
    logic [NIBBLE_W-1:0] a_nib, b_nib, b_op, s_out;
    logic               s_c, slice_c;

`ifdef ADDER_SCHED_SUB_EN
    logic sub_q;
    assign sub_sel = acc1 ? req1_sub : req0_sub;
`else
    localparam logic sub_q = 1'b0;
    assign sub_sel = 1'b0;
`endif

    // Round-robin: on contention the requester not served last wins.
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready = rst_n & (state == IDLE) & grant0;
    assign req1_ready = rst_n & (state == IDLE) & grant1;
    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;

    assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = sub_q ? ~b_q[idx*NIBBLE_W +: NIBBLE_W] : b_q[idx*NIBBLE_W +: NIBBLE_W];

    // The slice has no carry-in, so fold it into b; b=F with carry-in wraps to 0 and
    // the lost carry is restored below.
    assign b_op    = b_nib + {{(NIBBLE_W-1){1'b0}}, cy_q};
    assign slice_c = s_c | (cy_q & (&b_nib));

    adder_par u_slice (
        .a     (a_nib),
        .b     (b_op),
        .out   (s_out),
        .carry (s_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            cy_q      <= 1'b0;
            idx       <= '0;
            last_q    <= 1'b1;
`ifdef ADDER_SCHED_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 | acc1) begin
                        a_q    <= acc1 ? req1_a : req0_a;
                        b_q    <= acc1 ? req1_b : req0_b;
                        id_q   <= acc1;
                        last_q <= acc1;
                        cy_q   <= sub_sel;
                        idx    <= '0;
`ifdef ADDER_SCHED_SUB_EN
                        sub_q  <= sub_sel;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_sum[idx*NIBBLE_W +: NIBBLE_W] <= s_out;
                    cy_q <= slice_c;
                    idx  <= idx + 1'b1;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        res_carry <= slice_c;
                        res_id    <= id_q;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
